// File: rtl/div_unit_if.sv
// Divider request/response bundle between EX and div_unit.
// EX holds START until READY; RESULT is valid only while READY is high.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 SIGNED_DIV;
  logic [WIDTH-1:0]     OPDATA1;
  logic [WIDTH-1:0]     OPDATA2;
  logic                 START;
  logic                 ANNUL;
  logic [2*WIDTH-1:0]   RESULT;
  logic                 READY;

  modport master (
    output SIGNED_DIV, OPDATA1, OPDATA2, START, ANNUL,
    input  RESULT, READY
  );

  modport slave (
    input  SIGNED_DIV, OPDATA1, OPDATA2, START, ANNUL,
    output RESULT, READY
  );
endinterface

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, READY WIDTH+1 edges after acceptance
// (2 edges for a zero divisor); result is held while START stays high and cleared once it drops.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      CLK,
  input  logic      RST,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] w, w_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [WIDTH-1:0]   divisor, divisor_nxt;
  logic               neg_q, neg_q_nxt;
  logic               neg_r, neg_r_nxt;
  logic [2*WIDTH-1:0] result, result_nxt;
  logic               ready, ready_nxt;

  logic               accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign accept = bus.START && !bus.ANNUL;
  assign abs_a  = (bus.SIGNED_DIV && bus.OPDATA1[WIDTH-1]) ? (~bus.OPDATA1 + ONE) : bus.OPDATA1;
  assign abs_b  = (bus.SIGNED_DIV && bus.OPDATA2[WIDTH-1]) ? (~bus.OPDATA2 + ONE) : bus.OPDATA2;

  // Partial remainder lives in w's upper half; shifting first makes it WIDTH+1 bits, so diff's
  // top bit is a reliable borrow (the remainder is always below the divisor).
  assign shifted = {w, 1'b0};
  assign diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
  assign q_fix   = neg_q ? (~w[WIDTH-1:0] + ONE) : w[WIDTH-1:0];
  assign r_fix   = neg_r ? (~w[2*WIDTH-1:WIDTH] + ONE) : w[2*WIDTH-1:WIDTH];

  always_ff @(posedge CLK) begin
    if (RST) state <= FREE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FREE:    if (accept) state_nxt = (bus.OPDATA2 == '0) ? BY_ZERO : ON;
      BY_ZERO: if (bus.ANNUL) state_nxt = FREE;
               else if (cnt != '0) state_nxt = END;
      ON:      if (bus.ANNUL) state_nxt = FREE;
               else if (cnt == CNT_LAST) state_nxt = END;
      END:     if (!bus.START) state_nxt = FREE;
      default: state_nxt = FREE;
    endcase
  end

  always_comb begin
    w_nxt       = w;
    cnt_nxt     = cnt;
    divisor_nxt = divisor;
    neg_q_nxt   = neg_q;
    neg_r_nxt   = neg_r;
    result_nxt  = result;
    ready_nxt   = ready;
    case (state)
      FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        if (accept) begin
          cnt_nxt     = '0;
          w_nxt       = {{WIDTH{1'b0}}, abs_a};
          divisor_nxt = abs_b;
          neg_q_nxt   = bus.SIGNED_DIV && (bus.OPDATA1[WIDTH-1] ^ bus.OPDATA2[WIDTH-1]);
          neg_r_nxt   = bus.SIGNED_DIV && bus.OPDATA1[WIDTH-1];
        end
      end
      BY_ZERO: begin
        if (!bus.ANNUL) begin
          // One idle cycle keeps the zero-divisor answer two edges after acceptance.
          if (cnt == '0) begin
            cnt_nxt = CNT_ONE;
          end else begin
            result_nxt = '0;
            ready_nxt  = 1'b1;
          end
        end
      end
      ON: begin
        if (!bus.ANNUL) begin
          if (cnt != CNT_LAST) begin
            if (diff[WIDTH]) w_nxt = shifted[2*WIDTH-1:0];
            else             w_nxt = {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
            cnt_nxt = cnt + CNT_ONE;
          end else begin
            result_nxt = {r_fix, q_fix};
            ready_nxt  = 1'b1;
          end
        end
      end
      END: begin
        if (!bus.START) begin
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      end
      default: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      w       <= '0;
      cnt     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      w       <= w_nxt;
      cnt     <= cnt_nxt;
      divisor <= divisor_nxt;
      neg_q   <= neg_q_nxt;
      neg_r   <= neg_r_nxt;
      result  <= result_nxt;
      ready   <= ready_nxt;
    end
  end

  assign bus.RESULT = result;
  assign bus.READY  = ready;
endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, zero divisor, annul, reset.
module tb_div_unit;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  div_unit_if #(.WIDTH(W)) bus();
  div_unit #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents an operation, lets the next edge accept it, and counts edges until READY.
  task automatic run_op(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [2*W-1:0] res);
    bus.SIGNED_DIV = sd;
    bus.OPDATA1    = a;
    bus.OPDATA2    = b;
    bus.ANNUL      = 1'b0;
    bus.START      = 1'b1;
    tick();
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (bus.READY === 1'b1) begin
        lat = n;
        break;
      end
    end
    res = bus.RESULT;
  endtask

  task automatic drop_start();
    bus.START = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.SIGNED_DIV = 1'b0;
    bus.OPDATA1    = '0;
    bus.OPDATA2    = '0;
    bus.START      = 1'b0;
    bus.ANNUL      = 1'b0;
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.READY !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=0", bus.READY);
    end
    checks++;
    if (bus.RESULT !== 64'h0) begin
      errors++;
      $display("FAIL reset_result got=%h exp=0", bus.RESULT);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    int lat;
    logic [2*W-1:0] res;
    run_op(1'b0, 32'd100, 32'd7, lat, res);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL divu_latency got=%0d exp=33", lat);
    end
    checks++;
    if (res !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL divu_100_7 got=%h exp=000000020000000e", res);
    end
    repeat (3) tick();
    checks++;
    if (bus.READY !== 1'b1 || bus.RESULT !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL divu_hold ready=%b result=%h exp ready=1 result=000000020000000e",
               bus.READY, bus.RESULT);
    end
    drop_start();
  endtask

  task automatic test_signed();
    int lat;
    logic [2*W-1:0] res;
    run_op(1'b1, 32'hFFFFFFF9, 32'h00000002, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++;
      $display("FAIL div_m7_2 lat=%0d got=%h exp lat=33 result=fffffffffffffffd", lat, res);
    end
    drop_start();
    run_op(1'b1, 32'h00000007, 32'hFFFFFFFE, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000001_FFFFFFFD) begin
      errors++;
      $display("FAIL div_7_m2 lat=%0d got=%h exp lat=33 result=00000001fffffffd", lat, res);
    end
    drop_start();
  endtask

  task automatic test_div_zero();
    int lat;
    logic [2*W-1:0] res;
    run_op(1'b0, 32'd5, 32'd0, lat, res);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL divzero_latency got=%0d exp=2", lat);
    end
    checks++;
    if (res !== 64'h0) begin
      errors++;
      $display("FAIL divzero_result got=%h exp=0", res);
    end
    drop_start();
    checks++;
    if (bus.READY !== 1'b0 || bus.RESULT !== 64'h0) begin
      errors++;
      $display("FAIL divzero_release ready=%b result=%h exp ready=0 result=0",
               bus.READY, bus.RESULT);
    end
    run_op(1'b0, 32'd9, 32'd3, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_00000003) begin
      errors++;
      $display("FAIL after_divzero lat=%0d got=%h exp lat=33 result=0000000000000003", lat, res);
    end
    drop_start();
  endtask

  task automatic test_annul();
    int lat;
    int ready_seen;
    logic [2*W-1:0] res;
    bus.SIGNED_DIV = 1'b0;
    bus.OPDATA1    = 32'd1000;
    bus.OPDATA2    = 32'd3;
    bus.START      = 1'b1;
    tick();
    repeat (10) tick();
    bus.ANNUL = 1'b1;
    bus.START = 1'b0;
    tick();
    bus.ANNUL = 1'b0;
    ready_seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.READY !== 1'b0 || bus.RESULT !== 64'h0) ready_seen++;
      tick();
    end
    checks++;
    if (ready_seen !== 0) begin
      errors++;
      $display("FAIL annul_quiet cycles_with_output=%0d exp=0", ready_seen);
    end
    run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_FFFFFFFF) begin
      errors++;
      $display("FAIL after_annul lat=%0d got=%h exp lat=33 result=00000000ffffffff", lat, res);
    end
    drop_start();
  endtask

  task automatic test_overflow();
    int lat;
    logic [2*W-1:0] res;
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_80000000) begin
      errors++;
      $display("FAIL div_overflow lat=%0d got=%h exp lat=33 result=0000000080000000", lat, res);
    end
    drop_start();
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h80000000_00000000) begin
      errors++;
      $display("FAIL divu_big lat=%0d got=%h exp lat=33 result=8000000000000000", lat, res);
    end
    drop_start();
  endtask

  task automatic test_reset_midop();
    int lat;
    int ready_seen;
    logic [2*W-1:0] res;
    bus.SIGNED_DIV = 1'b0;
    bus.OPDATA1    = 32'd50;
    bus.OPDATA2    = 32'd5;
    bus.START      = 1'b1;
    tick();
    repeat (20) tick();
    RST = 1'b1;
    tick();
    checks++;
    if (bus.READY !== 1'b0 || bus.RESULT !== 64'h0) begin
      errors++;
      $display("FAIL reset_midop ready=%b result=%h exp ready=0 result=0", bus.READY, bus.RESULT);
    end
    RST = 1'b0;
    bus.START = 1'b0;
    ready_seen = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.READY !== 1'b0) ready_seen++;
    end
    checks++;
    if (ready_seen !== 0) begin
      errors++;
      $display("FAIL reset_midop_quiet ready_cycles=%0d exp=0", ready_seen);
    end
    run_op(1'b0, 32'd50, 32'd5, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_0000000A) begin
      errors++;
      $display("FAIL after_reset lat=%0d got=%h exp lat=33 result=000000000000000a", lat, res);
    end
    drop_start();
  endtask

  task automatic test_annul_in_free();
    int lat;
    int ready_seen;
    bus.SIGNED_DIV = 1'b0;
    bus.OPDATA1    = 32'd12;
    bus.OPDATA2    = 32'd4;
    bus.START      = 1'b1;
    bus.ANNUL      = 1'b1;
    ready_seen = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (bus.READY !== 1'b0) ready_seen++;
    end
    checks++;
    if (ready_seen !== 0) begin
      errors++;
      $display("FAIL annul_free_ready ready_cycles=%0d exp=0", ready_seen);
    end
    bus.ANNUL = 1'b0;
    tick();
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (bus.READY === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== 33 || bus.RESULT !== 64'h00000000_00000003) begin
      errors++;
      $display("FAIL annul_free_then_op lat=%0d got=%h exp lat=33 result=0000000000000003",
               lat, bus.RESULT);
    end
    drop_start();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_overflow();
    test_reset_midop();
    test_annul_in_free();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
